// File: rtl/ula_seq_n_bits_pkg.sv
// Shared definitions for the sequential slice ALU.
// State encoding, opcodes and the overflow rule.
package ula_pkg;

  localparam int SLICE_W = 4;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed overflow of the full-width add or subtract; 0 otherwise.
  function automatic logic ovf_calc(
    input logic       m,
    input logic [3:0] s,
    input logic       a_msb,
    input logic       b_msb,
    input logic       f_msb
  );
    logic r;
    r = 1'b0;
    if (!m && s == OP_ADD)
      r = (a_msb == b_msb) && (f_msb != a_msb);
    else if (!m && s == OP_SUB)
      r = (a_msb != b_msb) && (f_msb == b_msb);
    return r;
  endfunction

endpackage

// File: rtl/ula_74181.sv
// One 4-bit 74181-style ALU slice, active-high data.
// Carries are active-low; p_o/g_o are active-high group terms.
module ula_74181
  import ula_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic [3:0]         s_i,
  input  logic               m_i,
  input  logic               c_in_i,
  output logic [SLICE_W-1:0] f_o,
  output logic               a_eq_b_o,
  output logic               c_out_o,
  output logic               c_ripple_o,
  output logic               p_o,
  output logic               g_o
);

  logic [3:0] pn;
  logic [3:0] gn;
  logic [3:0] pa;
  logic [3:0] ga;
  logic [3:0] hs;
  logic [4:0] c;

  // Per-bit propagate/generate, internal ripple, and result.
  always_comb begin
    pn = ~(a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}}));
    gn = ~((a_i & ~b_i & {4{s_i[2]}}) | (a_i & b_i & {4{s_i[3]}}));
    pa = ~pn;
    ga = ~gn;
    hs = ~(pn ^ gn);
    c = '0;
    c[0] = ~c_in_i;
    for (int i = 0; i < 4; i++)
      c[i+1] = ga[i] | (pa[i] & c[i]);
    f_o = hs ^ ({4{~m_i}} & ~c[3:0]);
  end

  assign a_eq_b_o   = &f_o;
  assign c_out_o    = ~c[4];
  assign c_ripple_o = ~c[4];
  assign p_o        = &pa;
  assign g_o        = ga[3]
                    | (pa[3] & ga[2])
                    | (pa[3] & pa[2] & ga[1])
                    | (pa[3] & pa[2] & pa[1] & ga[0]);

endmodule

// File: rtl/ula_seq_n_bits.sv
// N-bit ALU evaluated one 4-bit slice per cycle
// through a single time-multiplexed 74181 slice.
module ula_seq_n_bits
  import ula_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             a_eq_b,
  output logic             c_out,
  output logic             overflow,
  output logic             p,
  output logic             g
);

  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef logic [NSLICE-1:0][SLICE_W-1:0] vec_t;

  state_t      state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  vec_t        a_q, a_d;
  vec_t        b_q, b_d;
  vec_t        res_q, res_d;
  vec_t        f_q, f_d;
  logic [3:0]  s_q, s_d;
  logic        m_q, m_d;
  logic        ci_q, ci_d;
  logic        cr_q, cr_d;
  logic        eq_q, eq_d;
  logic        pa_q, pa_d;
  logic        ga_q, ga_d;
  logic        aeqb_q, aeqb_d;
  logic        co_q, co_d;
  logic        ov_q, ov_d;
  logic        p_q, p_d;
  logic        g_q, g_d;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_f;
  logic        sl_ci;
  logic        sl_eq;
  logic        sl_co;
  logic        sl_cr;
  logic        sl_p;
  logic        sl_g;
  logic        last;
  vec_t        res_n;
  logic        eq_n;
  logic        pa_n;
  logic        ga_n;

  assign sl_a  = a_q[k_q];
  assign sl_b  = b_q[k_q];
  assign sl_ci = (k_q == '0) ? ci_q : cr_q;
  assign last  = (k_q == KW'(NSLICE - 1));

  ula_74181 u_slice (
    .a_i        (sl_a),
    .b_i        (sl_b),
    .s_i        (s_q),
    .m_i        (m_q),
    .c_in_i     (sl_ci),
    .f_o        (sl_f),
    .a_eq_b_o   (sl_eq),
    .c_out_o    (sl_co),
    .c_ripple_o (sl_cr),
    .p_o        (sl_p),
    .g_o        (sl_g)
  );

  // Accumulators after folding in the current slice.
  always_comb begin
    res_n      = res_q;
    res_n[k_q] = sl_f;
    eq_n       = eq_q & sl_eq;
    pa_n       = pa_q & sl_p;
    ga_n       = sl_g | (sl_p & ga_q);
  end

  // FSM; results are loaded on entry to DONE so they show with done.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    ci_d    = ci_q;
    cr_d    = cr_q;
    res_d   = res_q;
    eq_d    = eq_q;
    pa_d    = pa_q;
    ga_d    = ga_q;
    f_d     = f_q;
    aeqb_d  = aeqb_q;
    co_d    = co_q;
    ov_d    = ov_q;
    p_d     = p_q;
    g_d     = g_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          ci_d    = c_in;
          k_d     = '0;
          res_d   = '0;
          eq_d    = 1'b1;
          pa_d    = 1'b1;
          ga_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d = res_n;
        eq_d  = eq_n;
        pa_d  = pa_n;
        ga_d  = ga_n;
        cr_d  = sl_cr;
        k_d   = k_q + KW'(1);
        if (last) begin
          f_d     = res_n;
          aeqb_d  = eq_n;
          p_d     = pa_n;
          g_d     = ga_n;
          co_d    = sl_co;
          ov_d    = ovf_calc(m_q, s_q,
                             a_q[NSLICE-1][SLICE_W-1],
                             b_q[NSLICE-1][SLICE_W-1],
                             res_n[NSLICE-1][SLICE_W-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      ci_q    <= 1'b0;
      cr_q    <= 1'b0;
      res_q   <= '0;
      eq_q    <= 1'b0;
      pa_q    <= 1'b0;
      ga_q    <= 1'b0;
      f_q     <= '0;
      aeqb_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      ci_q    <= ci_d;
      cr_q    <= cr_d;
      res_q   <= res_d;
      eq_q    <= eq_d;
      pa_q    <= pa_d;
      ga_q    <= ga_d;
      f_q     <= f_d;
      aeqb_q  <= aeqb_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      p_q     <= p_d;
      g_q     <= g_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign f        = f_q;
  assign a_eq_b   = aeqb_q;
  assign c_out    = co_q;
  assign overflow = ov_q;
  assign p        = p_q;
  assign g        = g_q;

endmodule

// File: doc/ula_seq_n_bits.md
ULA_SEQ_N_BITS -- requirements
Module: ula_seq_n_bits

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 with WIDTH >= 8.
REQ-002 The block SHALL have parameter NSLICE = WIDTH/4, derived and not overridable, giving the number of 4-bit slices.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with the port list as follows: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-004 The block SHALL have input ports: start 1, request pulse; a WIDTH, operand A; b WIDTH, operand B; s 4, function select; m 1, mode (1=logic, 0=arithmetic); c_in 1, carry into slice 0.
REQ-005 The block SHALL have output ports: busy 1; done 1, one-cycle pulse; f WIDTH, result; a_eq_b 1; c_out 1; overflow 1; p 1; g 1.
REQ-006 Carry polarity on c_in and c_out SHALL be identical to ula_74181 c_in/c_out; the inter-slice carry SHALL use ula_74181 c_ripple semantics.

Function
REQ-007 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-008 In IDLE, start=1 SHALL latch a, b, s, m, c_in into operand registers, clear slice index k to 0, and move to RUN.
REQ-009 In RUN, each cycle SHALL evaluate slice k (bits 4k+3:4k) through the single ula_74181 instance, with carry in = c_in for k=0, else the registered c_ripple of slice k-1.
REQ-010 Per RUN cycle: store the slice F into the result shift register at nibble k; AND its a_eq_b into an equality accumulator (initialised to 1); P accumulator = P_acc AND p_k (initialised to 1); G accumulator = g_k OR (p_k AND G_acc) (initialised to 0).
REQ-011 When k = NSLICE-1, RUN SHALL move to DONE; c_out SHALL take that slice's c_out.
REQ-012 In DONE (exactly one cycle), the block SHALL update f, a_eq_b, p, g, c_out, and overflow from the accumulators, assert done=1, then return to IDLE.
REQ-013 Latency SHALL be NSLICE+1 cycles from the start-sampling edge to the edge at which done is high.
REQ-014 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-015 start while busy=1 SHALL be ignored, with no queuing; start in the same cycle as the DONE cycle SHALL be ignored.
REQ-016 overflow SHALL be computed from latched operands and the final f:
- add (m=0, s=1001): a[W-1]==b[W-1] and f[W-1]!=a[W-1];
- sub (m=0, s=0110): a[W-1]!=b[W-1] and f[W-1]==b[W-1];
- otherwise 0.
REQ-017 Outputs f, a_eq_b, c_out, overflow, p, g SHALL hold their last DONE value until the next DONE; input changes during RUN SHALL NOT affect the result.

Reset
REQ-018 rst=1 SHALL asynchronously force state IDLE and k=0, and set busy, done, f, a_eq_b, c_out, overflow, p, g, all accumulators, and operand registers to 0.
REQ-019 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted normally.

Structure
REQ-020 Package ula_pkg SHALL hold the FSM state enum, the opcode constants OP_ADD=4'b1001 and OP_SUB=4'b0110, and SLICE_W=4.
REQ-021 Exactly one ula_74181 sub-module instance SHALL be used, time-multiplexed across slices; no other sub-modules are permitted.

Verification (WIDTH=16 unless noted)
REQ-022 Scenario: a=16'h7FFF, b=16'h0001, m=0, s=1001, c_in=no-carry level -> done after 5 cycles, f=16'h8000, overflow=1.
REQ-023 Scenario: a=16'hF0F0, b=16'hFF00, m=1, s=0110 (XOR) -> f=16'h0FF0, overflow=0, busy high for exactly 5 cycles.
REQ-024 Scenario: a=b=16'h1234, m=0, s=0110, c_in=no-carry level -> f=16'hFFFF, a_eq_b=1; repeat with b=16'h1235 -> a_eq_b=0.
REQ-025 Scenario: assert rst on the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; a fresh start then completes correctly.
REQ-026 Scenario: start held high for 10 cycles -> exactly two operations accepted, at cycles 0 and 6; operand change mid-RUN does not alter f.
REQ-027 Scenario: WIDTH=32 random add/sub vectors versus a behavioural model -> f, c_out, overflow, p, g match, with latency 9 cycles.
